// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Encodings shared between the ALU decoder and the multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic MODE_MULTU = 1'b0;
    localparam logic MODE_MULT  = 1'b1;

    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] MULTU = 6'b011001;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/seq_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier_if
// Description : Request/result bundle between the ALU and the multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_multiplier_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     dataA;
    logic [WIDTH-1:0]     dataB;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   dataOut;

    modport master (
        output start, is_signed, dataA, dataB,
        input  busy, done, dataOut
    );

    modport slave (
        input  start, is_signed, dataA, dataB,
        output busy, done, dataOut
    );
endinterface : seq_multiplier_if
`default_nettype wire

// File: rtl/mul_negate.sv
`default_nettype none
// ============================================================================
// Module      : mul_negate
// Description : Combinational two's-complement negator.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_negate #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] i_value,
    output logic      [WIDTH-1:0] o_negated
);

    assign o_negated = ~i_value + WIDTH'(1);

endmodule : mul_negate
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier
// Description : Shift-add multiplier, one multiplier bit per cycle, with a
//               sign-correction cycle for MULT.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic        clk,
    input  wire logic        reset,
    seq_multiplier_if.slave  bus
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_accept;

    logic [WIDTH-1:0]       r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [2*WIDTH-1:0]     r_product;
    logic [2*WIDTH-1:0]     r_data_out;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_neg;
    logic                   r_done;

    logic                   w_signed;
    logic                   w_a_neg;
    logic                   w_b_neg;
    logic [WIDTH-1:0]       w_neg_a;
    logic [WIDTH-1:0]       w_neg_b;
    logic [WIDTH-1:0]       w_a_mag;
    logic [WIDTH-1:0]       w_b_mag;
    logic [2*WIDTH-1:0]     w_neg_prod;
    logic [WIDTH-1:0]       w_addend;
    logic [WIDTH:0]         w_sum;

    mul_negate #(.WIDTH(WIDTH)) u_neg_a (
        .i_value   (bus.dataA),
        .o_negated (w_neg_a)
    );

    mul_negate #(.WIDTH(WIDTH)) u_neg_b (
        .i_value   (bus.dataB),
        .o_negated (w_neg_b)
    );

    mul_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
        .i_value   (r_product),
        .o_negated (w_neg_prod)
    );

    // The most negative operand negates to itself, which is exactly its
    // unsigned magnitude, so no special case is needed.
    assign w_signed = (bus.is_signed == MODE_MULT);
    assign w_a_neg  = w_signed & bus.dataA[WIDTH-1];
    assign w_b_neg  = w_signed & bus.dataB[WIDTH-1];
    assign w_a_mag  = w_a_neg ? w_neg_a : bus.dataA;
    assign w_b_mag  = w_b_neg ? w_neg_b : bus.dataB;

    // Keep the carry: it becomes the new product MSB after the shift.
    assign w_addend = r_mplier[0] ? r_mcand : '0;
    assign w_sum    = {1'b0, r_product[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = RUN;
                    w_accept    = 1'b1;
                end
            end
            RUN: begin
                if (r_cnt == c_CNT_W'(1)) begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                w_state_nxt = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    w_state_nxt = RUN;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_product  <= '0;
            r_data_out <= '0;
            r_cnt      <= '0;
            r_neg      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            if (r_state == DONE) begin
                r_data_out <= r_product;
            end
            if (w_accept) begin
                r_mcand   <= w_a_mag;
                r_mplier  <= w_b_mag;
                r_neg     <= w_a_neg ^ w_b_neg;
                r_product <= '0;
                r_cnt     <= c_CNT_W'(WIDTH);
            end else if (r_state == RUN) begin
                r_product <= {w_sum, r_product[WIDTH-1:1]};
                r_mplier  <= r_mplier >> 1;
                r_cnt     <= r_cnt - c_CNT_W'(1);
            end else if (r_state == FIX && r_neg) begin
                r_product <= w_neg_prod;
            end
        end
    end

    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = r_done;
    assign bus.dataOut = r_data_out;

endmodule : seq_multiplier
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_multiplier
// Description : Scoreboard bench for seq_multiplier at WIDTH=32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

    localparam int WIDTH   = 32;
    localparam int LATENCY = WIDTH + 2;

    typedef struct {
        logic [63:0] prod;
        int          due;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    exp_t sb[$];

    seq_multiplier_if #(.WIDTH(WIDTH)) bus ();

    seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", bus.dataOut, e.prod);
                check("latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] expv);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.dataA     = a;
        bus.dataB     = b;
        bus.is_signed = s;
        @(negedge clk);
        sb.push_back('{prod: expv, due: cyc + LATENCY});
        bus.start     = 1'b0;
        bus.dataA     = $urandom;
        bus.dataB     = $urandom;
        bus.is_signed = 1'($urandom_range(0, 1));
        check("busy_after_accept", 64'(bus.busy), 64'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 4 * LATENCY) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        check("busy_idle", 64'(bus.busy), 64'd0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] p;
    } vec_t;

    vec_t vecs[8];

    initial begin
        cyc   = 0;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dataA     = '0;
        bus.dataB     = '0;

        vecs[0] = '{32'd3,        32'd5,        1'b0, 64'd15};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001};
        vecs[2] = '{32'hFFFFFFFD, 32'd7,        1'b1, 64'hFFFFFFFF_FFFFFFEB};
        vecs[3] = '{32'hFFFFFFFC, 32'hFFFFFFFA, 1'b1, 64'd24};
        vecs[4] = '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000};
        vecs[5] = '{32'h80000000, 32'd1,        1'b1, 64'hFFFFFFFF_80000000};
        vecs[6] = '{32'd0,        32'hFFFFFFFB, 1'b1, 64'd0};
        vecs[7] = '{32'h80000000, 32'd2,        1'b0, 64'h00000001_00000000};

        repeat (3) @(negedge clk);
        check("reset_busy",    64'(bus.busy), 64'd0);
        check("reset_done",    64'(bus.done), 64'd0);
        check("reset_dataOut", bus.dataOut,   64'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].p);
            wait_drain();
        end

        // A start while busy must be ignored.
        issue(32'd6, 32'd7, 1'b0, 64'd42);
        repeat (10) @(negedge clk);
        bus.start = 1'b1;
        bus.dataA = 32'd9;
        bus.dataB = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain();
        repeat (LATENCY) @(negedge clk);

        // Continuous start: one result every LATENCY cycles.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.dataA     = 32'd10;
        bus.dataB     = 32'd10;
        @(negedge clk);
        sb.push_back('{prod: 64'd100, due: cyc + LATENCY});
        bus.dataA = 32'h12345678;
        bus.dataB = 32'h10;
        repeat (LATENCY) @(negedge clk);
        check("b2b_busy", 64'(bus.busy), 64'd1);
        sb.push_back('{prod: 64'h00000001_23456780, due: cyc + LATENCY});
        bus.dataA     = 32'hFFFFFFFF;
        bus.dataB     = 32'hFFFFFFFF;
        bus.is_signed = 1'b1;
        repeat (LATENCY) @(negedge clk);
        sb.push_back('{prod: 64'd1, due: cyc + LATENCY});
        bus.start = 1'b0;
        wait_drain();

        // Reset during the tenth RUN iteration aborts the multiply.
        issue(32'd123, 32'd456, 1'b0, 64'd0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("abort_busy",    64'(bus.busy), 64'd0);
        check("abort_done",    64'(bus.done), 64'd0);
        check("abort_dataOut", bus.dataOut,   64'd0);
        reset = 1'b0;
        repeat (LATENCY + 6) @(negedge clk);
        issue(32'd2, 32'd2, 1'b0, 64'd4);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_seq_multiplier
`default_nettype wire
